// File: rtl/imm_encoder.sv
// imm_encoder: two-stage valid/ready pipe packing a signed immediate into RV32I I/S/B/J fields,
// with byte-address generation; define RANGE_CHECK_EN to drop out-of-range requests and flag range_err.
module imm_encoder #(
  parameter int width     = 32,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        ImmSrc,
  input  logic [width-1:0]  Imm,
  input  logic [width-1:0]  Base,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [width-1:0]  Instr,
  output logic [ADDR_W-1:0] Addr,
  output logic              range_err
);
  logic              r_s1_valid;
  logic [1:0]        r_s1_src;
  logic [width-1:0]  r_s1_imm;
  logic [width-1:0]  r_s1_base;
  logic              r_out_valid;
  logic [width-1:0]  r_instr;
  logic [ADDR_W-1:0] r_addr;
  logic [width-1:0]  w_enc;
  logic              w_bad;
  logic              w_s1_adv;
  logic              w_s2_load;
  logic              w_unused_base;

  always_comb
    w_enc = r_s1_src == 2'b00 ? {r_s1_imm[11:0], r_s1_base[19:0]} :
            r_s1_src == 2'b01 ? {r_s1_imm[11:5], r_s1_base[24:12], r_s1_imm[4:0], r_s1_base[6:0]} :
            r_s1_src == 2'b10 ? {r_s1_imm[12], r_s1_imm[10:5], r_s1_base[24:12], r_s1_imm[4:1],
                                 r_s1_imm[11], r_s1_base[6:0]} :
                                {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11], r_s1_imm[19:12],
                                 r_s1_base[11:0]};

  // A bad word leaves S1 without needing S2 space, so it never stalls the pipe.
  assign w_s1_adv      = r_s1_valid & (!r_out_valid | out_ready | w_bad);
  assign w_s2_load     = w_s1_adv & !w_bad;
  assign in_ready      = !r_s1_valid | w_s1_adv;
  assign out_valid     = r_out_valid;
  assign Instr         = r_instr;
  assign Addr          = r_addr;
  assign w_unused_base = ^r_s1_base[31:25];

`ifdef RANGE_CHECK_EN
  logic signed [width-1:0] w_simm;
  logic                    r_range_err;
  assign w_simm    = r_s1_imm;
  assign range_err = r_range_err;
  always_comb
    w_bad = r_s1_src == 2'b00 || r_s1_src == 2'b01 ? (w_simm < -2048 || w_simm > 2047) :
            r_s1_src == 2'b10 ? (r_s1_imm[0] || w_simm < -4096 || w_simm > 4094) :
                                (r_s1_imm[0] || w_simm < -(2**20) || w_simm > 2**20 - 2);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_range_err <= 1'b0;
    else if (w_s1_adv & w_bad) r_range_err <= 1'b1;
`else
  logic w_unused_imm;
  assign w_bad        = 1'b0;
  assign range_err    = 1'b0;
  assign w_unused_imm = ^{r_s1_imm[31:21], r_s1_imm[0]};
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_src    <= '0;
      r_s1_imm    <= '0;
      r_s1_base   <= '0;
      r_out_valid <= 1'b0;
      r_instr     <= '0;
      r_addr      <= ADDR_W'(BASE_ADDR);
    end else begin
      if (in_valid & in_ready) begin
        r_s1_valid <= 1'b1;
        r_s1_src   <= ImmSrc;
        r_s1_imm   <= Imm;
        r_s1_base  <= Base;
      end else if (w_s1_adv) r_s1_valid <= 1'b0;
      if (w_s2_load) begin
        r_out_valid <= 1'b1;
        r_instr     <= w_enc;
      end else if (out_ready) r_out_valid <= 1'b0;
      if (r_out_valid & out_ready) r_addr <= r_addr + ADDR_W'(4);
    end
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: randomized scoreboard bench for imm_encoder, decoding each word with a reference
// immediate extender; RANGE_CHECK_EN selects the matching drop/flag expectations.
module tb_imm_encoder;
  logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic        in_ready, out_valid, range_err;
  logic [1:0]  ImmSrc = 0;
  logic [31:0] Imm = 0, Base = 0, Instr;
  logic [7:0]  Addr;

  typedef struct {
    logic [1:0]  src;
    logic [31:0] imm, base, exp;
    bit          use_exp, use_rt;
  } item_t;

  item_t       q[$];
  item_t       it;
  logic [31:0] cur_exp = 0;
  bit          cur_use_exp = 0, cur_use_rt = 0;
  logic [7:0]  exp_addr = 0, prev_a = 0;
  logic [31:0] prev_i = 0;
  bit          prev_stall = 0, saw_full = 0;
  int          n_cmp = 0, n_err = 0, n_pop = 0, or_mode = 0, or_start = 0, cyc = 0, p0 = 0;

  always #5 clk = ~clk;

  imm_encoder #(.width(32), .ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .ImmSrc(ImmSrc),
    .Imm(Imm), .Base(Base), .out_valid(out_valid), .out_ready(out_ready), .Instr(Instr),
    .Addr(Addr), .range_err(range_err));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference immediate extender (decode direction).
  function automatic logic [31:0] dec(input logic [31:0] i, input logic [1:0] s);
    case (s)
      2'b00:   return {{20{i[31]}}, i[31:20]};
      2'b01:   return {{20{i[31]}}, i[31:25], i[11:7]};
      2'b10:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction

  function automatic logic [31:0] fmask(input logic [1:0] s);
    case (s)
      2'b00:   return 32'hFFF00000;
      2'b11:   return 32'hFFFFF000;
      default: return 32'hFE000F80;
    endcase
  endfunction

  function automatic bit in_rng(input logic [1:0] s, input logic [31:0] imm);
    int v;
    v = $signed(imm);
    if (s < 2) return v >= -2048 && v <= 2047;
    if (s == 2) return v % 2 == 0 && v >= -4096 && v <= 4094;
    return v % 2 == 0 && v >= -(1 << 20) && v <= (1 << 20) - 2;
  endfunction

  initial forever begin
    @(posedge clk);
    #2;
    cyc++;
    out_ready = or_mode == 2 ? ($urandom_range(0, 1) != 0) :
                or_mode == 1 ? !((cyc - or_start) >= 3 && (cyc - or_start) <= 6) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst_n) prev_stall = 0;
    else begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 1);
        check("hold_instr", Instr, prev_i);
        check("hold_addr", 32'(Addr), 32'(prev_a));
      end
      if (in_valid && !in_ready) saw_full = 1;
      if (in_valid && in_ready) begin
        it.src = ImmSrc; it.imm = Imm; it.base = Base;
        it.exp = cur_exp; it.use_exp = cur_use_exp; it.use_rt = cur_use_rt;
`ifdef RANGE_CHECK_EN
        if (in_rng(ImmSrc, Imm)) q.push_back(it);
`else
        q.push_back(it);
`endif
      end
      if (out_valid && out_ready) begin
        check("q_nonempty", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          it = q.pop_front();
          n_pop++;
          check("addr", 32'(Addr), 32'(exp_addr));
          if (it.use_exp) check("instr", Instr, it.exp);
          if (it.use_rt) begin
            check("roundtrip", dec(Instr, it.src), it.imm);
            check("base_keep", Instr & ~fmask(it.src), it.base & ~fmask(it.src));
          end
          exp_addr += 8'd4;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_i = Instr;
      prev_a = Addr;
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 0;
    in_valid = 0;
    #1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_addr", 32'(Addr), 0);
    check("rst_instr", Instr, 0);
    check("rst_err", 32'(range_err), 0);
    q.delete();
    exp_addr = 0;
    @(posedge clk);
    #3 rst_n = 1;
    @(negedge clk);
    check("rdy_after_rst", 32'(in_ready), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s, input logic [31:0] imm, input logic [31:0] base,
                      input logic [31:0] exp, input bit ue, input bit urt);
    bit ok;
    ok = 0;
    ImmSrc = s; Imm = imm; Base = base;
    cur_exp = exp; cur_use_exp = ue; cur_use_rt = urt;
    in_valid = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("send_timeout", 32'(ok), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    in_valid = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) begin
        ok = 1;
        break;
      end
    end
    check("drain", 32'(ok), 1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_imm(input logic [1:0] s);
    if (s < 2) return 32'($urandom_range(0, 4095)) - 32'd2048;
    if (s == 2) return (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
    return (32'($urandom_range(0, (1 << 20) - 1)) - 32'(1 << 19)) << 1;
  endfunction

  initial begin
    logic [1:0] s;
    do_reset();
    send(2'b00, 32'hFFFFFFFF, 32'h00000013, 32'hFFF00013, 1, 1);
    in_valid = 0;
    @(negedge clk);
    check("lat_edge_n", 32'(out_valid), 0);
    @(negedge clk);
    check("lat_edge_n1", 32'(out_valid), 1);
    @(posedge clk);
    #1;
    send(2'b01, 32'h000007FF, 32'h00002023, 32'h7E002FA3, 1, 1);
    send(2'b11, 32'h00000800, 32'h0000006F, 32'h0010006F, 1, 1);
    drain();

    do_reset();
    saw_full = 0;
    p0 = n_pop;
    or_start = cyc;
    or_mode = 1;
    for (int k = 0; k < 8; k++) send(2'b00, rnd_imm(2'b00), $urandom, 0, 0, 1);
    drain();
    check("stall_in_ready_low", 32'(saw_full), 1);
    check("stall_words", 32'(n_pop - p0), 8);

    or_mode = 2;
    for (int n = 0; n < 10000; n++) begin
      if (n == 5000) do_reset();
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 0;
        @(posedge clk);
        #1;
      end
      s = 2'($urandom_range(0, 3));
      send(s, rnd_imm(s), $urandom, 0, 0, 1);
    end
    drain();
    or_mode = 0;

    do_reset();
    p0 = n_pop;
    send(2'b00, 32'd5, 32'h00000013, 32'h00500013, 1, 1);
    send(2'b10, 32'd4096, 32'h00000063, 32'h80000063, 1, 0);
    send(2'b01, 32'hFFFFFFFC, 32'h00002023, 32'hFE002E23, 1, 1);
    drain();
    repeat (4) @(posedge clk);
    #1;
`ifdef RANGE_CHECK_EN
    check("range_words", 32'(n_pop - p0), 2);
    check("range_err_set", 32'(range_err), 1);
    repeat (5) @(posedge clk);
    #1;
    check("range_err_sticky", 32'(range_err), 1);
`else
    check("range_words", 32'(n_pop - p0), 3);
    check("range_err_zero", 32'(range_err), 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5ms;
    n_err++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
